imem_fetch_ctrl: RTL

- Fetch sequencer in front of the combinational InstructionMemory (address in, 32-bit instruction out, same cycle).
- Owns the PC and drives the memory address every cycle.
- Captures {pc, instruction} pairs into a small fetch queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute (queue flush) and a halt request from the pipeline control.

---
 rtl/imem_fetch_pkg.sv | 26 ++
 rtl/imem_fetch_ctrl_if.sv | 47 ++++
 rtl/imem_fetch_ctrl_queue.sv | 67 ++++++
 rtl/imem_fetch_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// ============================================================================
// imem_fetch_pkg : shared types and constants for the instruction fetch sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  // Queue entries carry a full 32-bit pc; narrower address widths are zero-extended.
  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
// ============================================================================
// imem_fetch_ctrl_if : memory, decode-handshake and redirect/halt signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface imem_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  halt_req;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_target,
    input  halt_req
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_target,
    output halt_req
  );

endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl_queue.sv
// ============================================================================
// fetch_queue : synchronous FIFO of {pc, instr} entries with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         push,
  input  wire logic         pop,
  input  wire logic         flush,
  input  wire fetch_entry_t wr_entry,
  output      fetch_entry_t head,
  output      logic         full,
  output      logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A pop frees the slot the push may claim, so a full queue still streams.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_entry;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// imem_fetch_ctrl : PC owner and fetch FSM feeding decode through a fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  imem_fetch_ctrl_if.master bus,
  output      logic [1:0]  state_o,
  output      logic [31:0] retire_count
);

  fetch_state_e          r_state;
  fetch_state_e          w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_retire;
  logic                  w_fetch_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  fetch_entry_t          w_wr_entry;
  fetch_entry_t          w_head;
  logic                  w_unused_tgt_lsbs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  // Next state: halt outranks a simultaneous redirect; BOOT always advances.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = RUN;
      RUN:     if (bus.halt_req) w_next_state = HALTED;
      HALTED:  if (bus.redirect_valid) w_next_state = bus.halt_req ? HALTED : RUN;
      default: w_next_state = BOOT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    state_o    = r_state;
    w_fetch_en = (r_state == RUN);
  end

  assign w_redirect_pc     = {bus.redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_tgt_lsbs = ^bus.redirect_target[1:0];

  // A redirect flushes the queue, so any handshake that cycle is void.
  assign w_pop  = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign w_push = w_fetch_en && !bus.redirect_valid && !bus.halt_req && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_retire <= '0;
    else if (w_pop) r_retire <= r_retire + 32'd1;
  end

  assign w_wr_entry = '{pc: PC_W'(r_pc), instr: bus.imem_instr};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (bus.redirect_valid),
    .wr_entry (w_wr_entry),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_instr = w_head.instr;
  assign bus.out_pc    = w_head.pc[ADDR_WIDTH-1:0];
  assign retire_count  = r_retire;

endmodule

`default_nettype wire
